// File: rtl/xadac_pkg.sv
// rtl/xadac_pkg.sv - shared sizing and channel payload types for the xadac port
package xadac_pkg;

  localparam int SbLen        = 4;
  localparam int IdWidth      = $clog2(SbLen);
  localparam int AddrWidth    = 32;
  localparam int InstrWidth   = 32;
  localparam int RegDataWidth = 32;
  localparam int VecDataWidth = 64;
  localparam int VecElemWidth = 8;
  localparam int VecNumElems  = VecDataWidth / VecElemWidth;
  localparam int VecLenWidth  = 4;
  localparam int NoRs         = 2;
  localparam int NoVs         = 3;

  typedef logic [IdWidth-1:0]      IdT;
  typedef logic [AddrWidth-1:0]    AddrT;
  typedef logic [InstrWidth-1:0]   InstrT;
  typedef logic [RegDataWidth-1:0] RegDataT;
  typedef logic [VecDataWidth-1:0] VecDataT;
  typedef logic [VecLenWidth-1:0]  VecLenT;

  typedef struct packed {
    IdT    id;
    InstrT instr;
  } DecReqT;

  typedef struct packed {
    IdT              id;
    logic [NoRs-1:0] rs_read;
    logic            rd_clobber;
    logic [NoVs-1:0] vs_read;
    logic            vd_clobber;
    logic            accept;
  } DecRspT;

  typedef struct packed {
    IdT                 id;
    InstrT              instr;
    RegDataT [NoRs-1:0] rs_data;
    VecDataT [NoVs-1:0] vs_data;
  } ExeReqT;

  typedef struct packed {
    IdT      id;
    RegDataT rd_data;
    VecDataT vd_data;
  } ExeRspT;

endpackage

// File: rtl/xadac_if.sv
// rtl/xadac_if.sv - core-to-accelerator decode/execute request and response channels
interface xadac_if;
  import xadac_pkg::*;

  logic   dec_req_valid;
  logic   dec_req_ready;
  DecReqT dec_req;
  logic   dec_rsp_valid;
  logic   dec_rsp_ready;
  DecRspT dec_rsp;
  logic   exe_req_valid;
  logic   exe_req_ready;
  ExeReqT exe_req;
  logic   exe_rsp_valid;
  logic   exe_rsp_ready;
  ExeRspT exe_rsp;

  modport slv (
    input  dec_req_valid, dec_req, dec_rsp_ready,
    input  exe_req_valid, exe_req, exe_rsp_ready,
    output dec_req_ready, dec_rsp_valid, dec_rsp,
    output exe_req_ready, exe_rsp_valid, exe_rsp
  );

  modport mst (
    output dec_req_valid, dec_req, dec_rsp_ready,
    output exe_req_valid, exe_req, exe_rsp_ready,
    input  dec_req_ready, dec_rsp_valid, dec_rsp,
    input  exe_req_ready, exe_rsp_valid, exe_rsp
  );

endinterface

// File: rtl/xadac_sb_pick.sv
// rtl/xadac_sb_pick.sv - lowest-index find-first over a scoreboard ready vector
module xadac_sb_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]                           i_req,
  output logic                                   o_valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]   o_idx
);

  localparam int IdxW = (N > 1) ? $clog2(N) : 1;

  // scan from the top so the lowest set bit wins
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IdxW'(i);
    end
  end

endmodule

// File: rtl/xadac_vload.sv
// rtl/xadac_vload.sv - vector load unit: xadac exe requests to AXI AR/R reads
module xadac_vload
  import xadac_pkg::*;
(
  input  logic    clk,
  input  logic    rstn,
  xadac_if.slv    slv,
  output IdT      axi_ar_id,
  output AddrT    axi_ar_addr,
  output logic    axi_ar_valid,
  input  logic    axi_ar_ready,
  input  IdT      axi_r_id,
  input  VecDataT axi_r_data,
  input  logic    axi_r_valid,
  output logic    axi_r_ready
);

  typedef logic [VecLenWidth-1:0] ilen_t;

  typedef struct packed {
    AddrT    addr;
    VecLenT  vlen;
    VecDataT data;
    logic    exe_req_done;
    logic    axi_ar_done;
    logic    axi_r_done;
    logic    exe_rsp_done;
  } sb_entry_t;

  // scoreboard state and its staged next-state views (exe -> ar -> r -> rsp -> clean)
  sb_entry_t r_sb       [SbLen];
  sb_entry_t w_sb_exe   [SbLen];
  sb_entry_t w_sb_ar    [SbLen];
  sb_entry_t w_sb_r     [SbLen];
  sb_entry_t w_sb_rsp   [SbLen];
  sb_entry_t w_sb_nxt   [SbLen];

  logic      r_ar_valid;
  IdT        r_ar_id;
  AddrT      r_ar_addr;
  logic      r_rsp_valid;
  ExeRspT    r_rsp;

  DecRspT    w_dec_rsp;
  IdT        w_exe_id;
  VecLenT    w_exe_vlen;
  logic      w_exe_ready;
  logic      w_exe_hs;

  logic [SbLen-1:0] w_ar_cand;
  logic      w_ar_found;
  IdT        w_ar_idx;
  logic      w_ar_free;
  logic      w_ar_load;

  logic      w_r_ready;
  VecLenT    w_r_vlen;
  VecDataT   w_r_data;

  logic [SbLen-1:0] w_rsp_cand;
  logic      w_rsp_found;
  IdT        w_rsp_idx;
  logic      w_rsp_free;
  logic      w_rsp_load;
  ExeRspT    w_rsp_pay;

  logic      w_unused;

  // decode answers immediately: reads rs0 only and always writes vd
  always_comb begin
    w_dec_rsp            = '0;
    w_dec_rsp.id         = slv.dec_req.id;
    w_dec_rsp.rs_read    = 2'b01;
    w_dec_rsp.vd_clobber = 1'b1;
    w_dec_rsp.accept     = 1'b1;
  end

  assign slv.dec_rsp_valid = slv.dec_req_valid;
  assign slv.dec_req_ready = slv.dec_req_valid && slv.dec_rsp_ready;
  assign slv.dec_rsp       = w_dec_rsp;

  assign w_exe_id       = slv.exe_req.id;
  assign w_exe_vlen     = slv.exe_req.instr[25 +: VecLenWidth];
  assign w_exe_ready    = slv.exe_req_valid && !r_sb[w_exe_id].exe_req_done;
  assign w_exe_hs       = slv.exe_req_valid && w_exe_ready;
  assign slv.exe_req_ready = w_exe_ready;

  // capture a new request; zero-length loads complete without touching AXI
  always_comb begin
    w_sb_exe = r_sb;
    if (w_exe_hs) begin
      w_sb_exe[w_exe_id].addr         = slv.exe_req.rs_data[0];
      w_sb_exe[w_exe_id].vlen         = w_exe_vlen;
      w_sb_exe[w_exe_id].exe_req_done = 1'b1;
      if (w_exe_vlen == '0) begin
        w_sb_exe[w_exe_id].axi_ar_done = 1'b1;
        w_sb_exe[w_exe_id].axi_r_done  = 1'b1;
        w_sb_exe[w_exe_id].data        = '0;
      end
    end
  end

  // entries still waiting for their AR, including one accepted this cycle
  always_comb begin
    w_ar_cand = '0;
    for (int i = 0; i < SbLen; i++) begin
      w_ar_cand[i] = w_sb_exe[i].exe_req_done && !w_sb_exe[i].axi_ar_done;
    end
  end

  xadac_sb_pick #(.N(SbLen)) u_ar_pick (
    .i_req   (w_ar_cand),
    .o_valid (w_ar_found),
    .o_idx   (w_ar_idx)
  );

  assign w_ar_free = !r_ar_valid || axi_ar_ready;
  assign w_ar_load = w_ar_free && w_ar_found;

  // mark the picked entry as issued when it moves into the AR register
  always_comb begin
    w_sb_ar = w_sb_exe;
    if (w_ar_load) w_sb_ar[w_ar_idx].axi_ar_done = 1'b1;
  end

  // only beats for an issued, not yet returned id are taken; anything else is refused
  assign w_r_ready   = axi_r_valid && r_sb[axi_r_id].axi_ar_done && !r_sb[axi_r_id].axi_r_done;
  assign axi_r_ready = w_r_ready;
  assign w_r_vlen    = r_sb[axi_r_id].vlen;

  // zero every element at or beyond the instruction's vector length
  always_comb begin
    w_r_data = '0;
    for (int i = 0; i < VecNumElems; i++) begin
      if (ilen_t'(i) < w_r_vlen) begin
        w_r_data[i*VecElemWidth +: VecElemWidth] = axi_r_data[i*VecElemWidth +: VecElemWidth];
      end
    end
  end

  // store the returned vector
  always_comb begin
    w_sb_r = w_sb_ar;
    if (w_r_ready) begin
      w_sb_r[axi_r_id].data       = w_r_data;
      w_sb_r[axi_r_id].axi_r_done = 1'b1;
    end
  end

  // entries with data ready to be returned, including one accepted this cycle
  always_comb begin
    w_rsp_cand = '0;
    for (int i = 0; i < SbLen; i++) begin
      w_rsp_cand[i] = w_sb_r[i].axi_r_done && !w_sb_r[i].exe_rsp_done;
    end
  end

  xadac_sb_pick #(.N(SbLen)) u_rsp_pick (
    .i_req   (w_rsp_cand),
    .o_valid (w_rsp_found),
    .o_idx   (w_rsp_idx)
  );

  assign w_rsp_free = !r_rsp_valid || slv.exe_rsp_ready;
  assign w_rsp_load = w_rsp_free && w_rsp_found;

  // response payload built from the picked entry
  always_comb begin
    w_rsp_pay         = '0;
    w_rsp_pay.id      = w_rsp_idx;
    w_rsp_pay.vd_data = w_sb_r[w_rsp_idx].data;
  end

  // mark returned, then free any entry whose life cycle is complete
  always_comb begin
    w_sb_rsp = w_sb_r;
    if (w_rsp_load) w_sb_rsp[w_rsp_idx].exe_rsp_done = 1'b1;
    for (int i = 0; i < SbLen; i++) begin
      if (w_sb_rsp[i].exe_req_done && w_sb_rsp[i].axi_ar_done &&
          w_sb_rsp[i].axi_r_done && w_sb_rsp[i].exe_rsp_done) begin
        w_sb_nxt[i] = '0;
      end else begin
        w_sb_nxt[i] = w_sb_rsp[i];
      end
    end
  end

  // scoreboard register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SbLen; i++) r_sb[i] <= '0;
    end else begin
      r_sb <= w_sb_nxt;
    end
  end

  // AR output register: refills in the same cycle it drains
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ar_valid <= 1'b0;
      r_ar_id    <= '0;
      r_ar_addr  <= '0;
    end else if (w_ar_free) begin
      r_ar_valid <= w_ar_found;
      r_ar_id    <= w_ar_found ? w_ar_idx : '0;
      r_ar_addr  <= w_ar_found ? w_sb_exe[w_ar_idx].addr : '0;
    end
  end

  // exe response output register: refills in the same cycle it drains
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
    end else if (w_rsp_free) begin
      r_rsp_valid <= w_rsp_found;
      r_rsp       <= w_rsp_found ? w_rsp_pay : '0;
    end
  end

  assign axi_ar_valid      = r_ar_valid;
  assign axi_ar_id         = r_ar_id;
  assign axi_ar_addr       = r_ar_addr;
  assign slv.exe_rsp_valid = r_rsp_valid;
  assign slv.exe_rsp       = r_rsp;

  // request fields this unit has no use for
  assign w_unused = ^{slv.dec_req.instr, slv.exe_req.instr, slv.exe_req.rs_data[1], slv.exe_req.vs_data};

endmodule

// File: tb/tb_xadac_vload.sv
// tb/tb_xadac_vload.sv - self-checking bench for xadac_vload
module tb_xadac_vload;
  import xadac_pkg::*;

  logic    clk = 1'b0;
  logic    rstn;
  IdT      ar_id;
  AddrT    ar_addr;
  logic    ar_valid;
  logic    ar_ready;
  IdT      r_id;
  VecDataT r_data;
  logic    r_valid;
  logic    r_ready;

  xadac_if u_if ();

  xadac_vload dut (
    .clk          (clk),
    .rstn         (rstn),
    .slv          (u_if.slv),
    .axi_ar_id    (ar_id),
    .axi_ar_addr  (ar_addr),
    .axi_ar_valid (ar_valid),
    .axi_ar_ready (ar_ready),
    .axi_r_id     (r_id),
    .axi_r_data   (r_data),
    .axi_r_valid  (r_valid),
    .axi_r_ready  (r_ready)
  );

  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;
  int cyc    = 0;

  // reference model: per-id life cycle of a load
  bit      m_busy    [SbLen];
  bit      m_ar_pend [SbLen];
  bit      m_r_pend  [SbLen];
  bit      m_shown   [SbLen];
  AddrT    m_addr    [SbLen];
  int      m_vlen    [SbLen];
  VecDataT m_rsp_q   [SbLen][$];
  int      exe_cyc   [SbLen];
  int      ar_cyc    [SbLen];
  int      r_cyc     [SbLen];
  int      show_cyc  [SbLen];
  IdT      ar_log  [$];
  IdT      rsp_log [$];
  VecDataT last_rsp_data;
  bit      exe_took, r_took;
  bit      ar_hold, rsp_hold;
  logic [IdWidth+AddrWidth-1:0] ar_prev;
  ExeRspT  rsp_prev;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic VecDataT mask(input VecDataT d, input int vlen);
    VecDataT m;
    if (vlen >= VecNumElems) m = '1;
    else m = (VecDataT'(1) << (VecElemWidth * vlen)) - VecDataT'(1);
    return d & m;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < SbLen; i++) begin
      m_busy[i] = 0; m_ar_pend[i] = 0; m_r_pend[i] = 0; m_shown[i] = 0;
      m_rsp_q[i].delete();
    end
    ar_hold = 0; rsp_hold = 0;
  endtask

  // evaluate everything that will handshake at the coming rising edge
  task automatic observe();
    DecRspT e;
    exe_took = 0;
    r_took   = 0;
    e = '0;
    e.id = u_if.dec_req.id; e.rs_read = 2'b01; e.vd_clobber = 1'b1; e.accept = 1'b1;
    chk("decode", 128'({u_if.dec_rsp_valid, u_if.dec_req_ready, u_if.dec_rsp}),
        128'({u_if.dec_req_valid, u_if.dec_req_valid && u_if.dec_rsp_ready, e}));
    if (rsp_hold) chk("rsp_stable", 128'({u_if.exe_rsp_valid, u_if.exe_rsp}), 128'({1'b1, rsp_prev}));
    if (u_if.exe_rsp_valid) begin
      IdT id = u_if.exe_rsp.id;
      if (!m_shown[id]) begin
        chk("rsp_expected", 128'(m_rsp_q[id].size() > 0), 128'(1));
        if (m_rsp_q[id].size() > 0) chk("rsp_data", 128'(u_if.exe_rsp.vd_data), 128'(m_rsp_q[id].pop_front()));
        chk("rsp_rd_zero", 128'(u_if.exe_rsp.rd_data), 128'(0));
        m_shown[id] = 1; m_busy[id] = 0; show_cyc[id] = cyc;
        rsp_log.push_back(id); last_rsp_data = u_if.exe_rsp.vd_data;
      end
      if (u_if.exe_rsp_ready) m_shown[id] = 0;
    end
    rsp_hold = u_if.exe_rsp_valid && !u_if.exe_rsp_ready;
    rsp_prev = u_if.exe_rsp;
    if (u_if.exe_req_valid) begin
      IdT id = u_if.exe_req.id;
      chk("exe_req_ready", 128'(u_if.exe_req_ready), 128'(!m_busy[id]));
      if (u_if.exe_req_ready) begin
        m_busy[id] = 1; exe_took = 1; exe_cyc[id] = cyc;
        m_addr[id] = u_if.exe_req.rs_data[0];
        m_vlen[id] = int'(u_if.exe_req.instr[28:25]);
        if (m_vlen[id] == 0) m_rsp_q[id].push_back('0);
        else m_ar_pend[id] = 1;
      end
    end
    if (ar_hold) chk("ar_stable", 128'({ar_valid, ar_id, ar_addr}), 128'({1'b1, ar_prev}));
    if (ar_valid && ar_ready) begin
      chk("ar_pending", 128'(m_ar_pend[ar_id]), 128'(1));
      chk("ar_addr", 128'(ar_addr), 128'(m_addr[ar_id]));
      m_ar_pend[ar_id] = 0; m_r_pend[ar_id] = 1; ar_cyc[ar_id] = cyc;
      ar_log.push_back(ar_id);
    end
    ar_hold = ar_valid && !ar_ready;
    ar_prev = {ar_id, ar_addr};
    if (r_valid) begin
      chk("r_ready", 128'(r_ready), 128'(m_r_pend[r_id]));
      if (r_ready) begin
        m_r_pend[r_id] = 0; r_took = 1; r_cyc[r_id] = cyc;
        m_rsp_q[r_id].push_back(mask(r_data, m_vlen[r_id]));
      end
    end else begin
      chk("r_ready_idle", 128'(r_ready), 128'(0));
    end
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exe(input int id, input AddrT addr, input int vlen);
    u_if.exe_req_valid      = 1'b1;
    u_if.exe_req.id         = IdT'(id);
    u_if.exe_req.instr      = ($urandom() & 32'hE1FF_FFFF) | (32'(vlen) << 25);
    u_if.exe_req.rs_data[0] = addr;
    u_if.exe_req.rs_data[1] = $urandom();
    for (int k = 0; k < NoVs; k++) u_if.exe_req.vs_data[k] = {$urandom(), $urandom()};
  endtask

  task automatic issue(input int id, input AddrT addr, input int vlen);
    set_exe(id, addr, vlen);
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (exe_took) break;
    end
    chk("exe_handshake_timeout", 128'(exe_took), 128'(1));
    u_if.exe_req_valid = 1'b0;
  endtask

  task automatic send_r(input int id, input VecDataT d);
    r_valid = 1'b1; r_id = IdT'(id); r_data = d;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (r_took) break;
    end
    chk("r_accept_timeout", 128'(r_took), 128'(1));
    r_valid = 1'b0;
  endtask

  task automatic wait_ar(input int id);
    for (int k = 0; k < 100 && !m_r_pend[id]; k++) cycle();
    chk("ar_timeout", 128'(m_r_pend[id]), 128'(1));
  endtask

  task automatic wait_rsps(input int n);
    int target = rsp_log.size() + n;
    for (int k = 0; k < 200 && rsp_log.size() < target; k++) cycle();
    chk("rsp_timeout", 128'(rsp_log.size() >= target), 128'(1));
  endtask

  function automatic bit any_busy();
    for (int i = 0; i < SbLen; i++) if (m_busy[i]) return 1;
    return 0;
  endfunction

  initial begin
    int mark;
    int pend[$];
    rstn = 1'b0;
    u_if.dec_req_valid = 0; u_if.dec_req = '0; u_if.dec_rsp_ready = 0;
    u_if.exe_req_valid = 0; u_if.exe_req = '0; u_if.exe_rsp_ready = 1;
    ar_ready = 1; r_valid = 0; r_id = '0; r_data = '0;
    reset_model();
    cycle(); cycle();
    r_valid = 1; r_id = IdT'($urandom_range(0, SbLen - 1)); r_data = {$urandom(), $urandom()};
    cycle();
    chk("rst_ar", 128'({ar_valid, ar_id, ar_addr}), 128'(0));
    chk("rst_rsp", 128'({u_if.exe_rsp_valid, u_if.exe_rsp}), 128'(0));
    r_valid = 0;
    rstn = 1'b1;
    cycle();

    // single load, vlen 4
    issue(2, 32'h1000, 4);
    wait_ar(2);
    chk("single_ar_latency", 128'(ar_cyc[2] - exe_cyc[2]), 128'(1));
    send_r(2, 64'h0807060504030201);
    wait_rsps(1);
    chk("single_rsp_id", 128'(rsp_log[rsp_log.size() - 1]), 128'(2));
    chk("single_vd", 128'(last_rsp_data), 128'(64'h04030201));
    chk("single_rsp_latency", 128'(show_cyc[2] - r_cyc[2]), 128'(1));

    // zero length, no AXI traffic
    mark = ar_log.size();
    issue(0, 32'h2000, 0);
    wait_rsps(1);
    chk("zero_rsp_latency", 128'(show_cyc[0] - exe_cyc[0]), 128'(1));
    chk("zero_rsp_id", 128'(rsp_log[rsp_log.size() - 1]), 128'(0));
    chk("zero_vd", 128'(last_rsp_data), 128'(0));
    cycle(); cycle();
    chk("zero_no_ar", 128'(ar_log.size()), 128'(mark));

    // out of order with AR backpressure
    ar_ready = 0;
    mark = ar_log.size();
    issue(0, 32'h3000, 8);
    issue(1, 32'h3100, 3);
    issue(2, 32'h3200, 5);
    cycle(); cycle(); cycle();
    ar_ready = 1;
    wait_ar(0); wait_ar(1); wait_ar(2);
    chk("ooo_ar_order", 128'({ar_log[mark], ar_log[mark + 1], ar_log[mark + 2]}), 128'({IdT'(0), IdT'(1), IdT'(2)}));
    mark = rsp_log.size();
    send_r(2, {$urandom(), $urandom()});
    send_r(0, {$urandom(), $urandom()});
    send_r(1, {$urandom(), $urandom()});
    wait_rsps(3 - (rsp_log.size() - mark));
    chk("ooo_rsp_order", 128'({rsp_log[mark], rsp_log[mark + 1], rsp_log[mark + 2]}), 128'({IdT'(2), IdT'(0), IdT'(1)}));

    // busy id stalls until the cycle after its rsp is loaded
    issue(1, 32'h4000, 2);
    wait_ar(1);
    set_exe(1, 32'h4100, 6);
    cycle(); cycle();
    chk("busy_stall", 128'(exe_took), 128'(0));
    r_valid = 1; r_id = IdT'(1); r_data = {$urandom(), $urandom()};
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (r_took) r_valid = 0;
      if (exe_took) break;
    end
    r_valid = 0;
    u_if.exe_req_valid = 0;
    chk("busy_accept_cycle", 128'(exe_cyc[1]), 128'(show_cyc[1]));
    wait_ar(1);
    send_r(1, {$urandom(), $urandom()});
    wait_rsps(1);

    // stray R id 3 is refused while another load proceeds
    r_valid = 1; r_id = IdT'(3); r_data = {$urandom(), $urandom()};
    issue(0, 32'h5000, 7);
    cycle(); cycle(); cycle();
    r_valid = 0;
    wait_ar(0);
    send_r(0, {$urandom(), $urandom()});
    wait_rsps(1);

    // reset with work in flight
    u_if.exe_rsp_ready = 0;
    issue(2, 32'h6000, 0);
    ar_ready = 0;
    issue(0, 32'h6100, 3);
    issue(1, 32'h6200, 6);
    cycle();
    chk("pre_rst_busy", 128'({ar_valid, u_if.exe_rsp_valid}), 128'(2'b11));
    rstn = 1'b0;
    #1;
    chk("midrst_ar", 128'({ar_valid, ar_id, ar_addr}), 128'(0));
    chk("midrst_rsp", 128'({u_if.exe_rsp_valid, u_if.exe_rsp}), 128'(0));
    reset_model();
    r_valid = 1; r_id = IdT'(0); r_data = {$urandom(), $urandom()};
    cycle(); cycle();
    rstn = 1'b1;
    cycle(); cycle();
    r_valid = 0;
    u_if.exe_rsp_ready = 1; ar_ready = 1;
    issue(0, 32'h7000, 5);
    wait_ar(0);
    send_r(0, {$urandom(), $urandom()});
    wait_rsps(1);
    chk("post_rst_rsp_id", 128'(rsp_log[rsp_log.size() - 1]), 128'(0));

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      if (!u_if.exe_req_valid && $urandom_range(0, 1) == 1)
        set_exe(int'($urandom_range(0, SbLen - 1)), $urandom(), int'($urandom_range(0, 8)));
      ar_ready = ($urandom_range(0, 3) != 0);
      u_if.exe_rsp_ready = ($urandom_range(0, 3) != 0);
      u_if.dec_req_valid = $urandom_range(0, 1) == 1;
      u_if.dec_req.id = IdT'($urandom_range(0, SbLen - 1));
      u_if.dec_req.instr = $urandom();
      u_if.dec_rsp_ready = $urandom_range(0, 1) == 1;
      if (!r_valid && $urandom_range(0, 1) == 1) begin
        pend.delete();
        for (int i = 0; i < SbLen; i++) if (m_r_pend[i]) pend.push_back(i);
        if (pend.size() > 0) begin
          r_valid = 1;
          r_id = IdT'(pend[$urandom_range(0, pend.size() - 1)]);
          r_data = {$urandom(), $urandom()};
        end
      end
      cycle();
      if (exe_took) u_if.exe_req_valid = 0;
      if (r_took) r_valid = 0;
    end

    // drain
    u_if.exe_req_valid = 0; ar_ready = 1; u_if.exe_rsp_ready = 1;
    for (int k = 0; k < 500 && any_busy(); k++) begin
      if (!r_valid) begin
        for (int i = 0; i < SbLen; i++) begin
          if (m_r_pend[i]) begin
            r_valid = 1; r_id = IdT'(i); r_data = {$urandom(), $urandom()};
            break;
          end
        end
      end
      cycle();
      if (r_took) r_valid = 0;
    end
    r_valid = 0;
    cycle(); cycle();
    chk("drain_idle", 128'(any_busy()), 128'(0));
    chk("drain_outputs", 128'({ar_valid, u_if.exe_rsp_valid}), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
